// File: rtl/hack_pkg.sv
// Shared definitions for the Hack execution core: FSM states, instruction
// field positions and jump-condition bit positions.
package hack_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int IR_CBIT    = 15;
    localparam int IR_ALU_MSB = 14;
    localparam int IR_ALU_LSB = 6;
    localparam int IR_ALU_W   = IR_ALU_MSB - IR_ALU_LSB + 1;
    localparam int IR_ABIT    = 12;
    localparam int IR_DEST_A  = 5;
    localparam int IR_DEST_D  = 4;
    localparam int IR_DEST_M  = 3;
    localparam int IR_JMP_MSB = 2;
    localparam int IR_JMP_LSB = 0;
    localparam int IR_JMP_W   = IR_JMP_MSB - IR_JMP_LSB + 1;

    // Bit positions inside the 3-bit jump field {lt, eq, gt}
    localparam int JMP_LT = 2;
    localparam int JMP_EQ = 1;
    localparam int JMP_GT = 0;

    localparam logic [IR_JMP_W-1:0] JMP_NEVER  = 3'b000;
    localparam logic [IR_JMP_W-1:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/hack_jump_unit.sv
// Jump condition: any enabled comparison of the ALU result against zero.
module hack_jump_unit
    import hack_pkg::*;
(
    input  logic [IR_JMP_W-1:0] jump,
    input  logic                zr,
    input  logic                ng,
    output logic                taken
);

    assign taken = (jump[JMP_LT] & ng)
                 | (jump[JMP_EQ] & zr)
                 | (jump[JMP_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_exec_core.sv
// Hack-style fetch/read/execute/write core around an external ALU, with
// req/ack handshakes to instruction and data memories.
module hack_exec_core
    import hack_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 15,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [15:0]           imem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [15:0]           dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [15:0]           dmem_rdata,
    output logic [15:0]           alu_x,
    output logic [15:0]           alu_y,
    output logic [IR_ALU_W-1:0]   alu_instruction,
    input  logic [15:0]           alu_out,
    input  logic                  alu_zr,
    input  logic                  alu_ng,
    output logic [ADDR_WIDTH-1:0] pc
);

    state_t                state;
    logic [15:0]           a, d, ir, mdr;
    logic [ADDR_WIDTH-1:0] a_addr, pc_inc;
    logic                  taken;

    assign a_addr          = a[ADDR_WIDTH-1:0];
    assign pc_inc          = pc + ADDR_WIDTH'(1);
    assign imem_addr       = pc;
    assign alu_x           = d;
    assign alu_y           = ir[IR_ABIT] ? mdr : a;
    assign alu_instruction = ir[IR_ALU_MSB:IR_ALU_LSB];

    hack_jump_unit u_jump (
        .jump  (ir[IR_JMP_MSB:IR_JMP_LSB]),
        .zr    (alu_zr),
        .ng    (alu_ng),
        .taken (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            a          <= '0;
            d          <= '0;
            ir         <= '0;
            mdr        <= '0;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // Only reached with req low right after reset; raise it first.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        if (imem_rdata[IR_CBIT] && imem_rdata[IR_ABIT]) begin
                            state     <= READ;
                            dmem_req  <= 1'b1;
                            dmem_we   <= 1'b0;
                            dmem_addr <= a_addr;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                READ: begin
                    if (dmem_req && dmem_ack) begin
                        mdr      <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (!ir[IR_CBIT]) begin
                        a        <= {1'b0, ir[14:0]};
                        pc       <= pc_inc;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        if (ir[IR_DEST_A]) a <= alu_out;
                        if (ir[IR_DEST_D]) d <= alu_out;
                        // Store address and jump target both use A before this update
                        dmem_wdata <= alu_out;
                        dmem_addr  <= a_addr;
                        pc         <= taken ? a_addr : pc_inc;
                        if (ir[IR_DEST_M]) begin
                            state    <= WRITE;
                            dmem_req <= 1'b1;
                            dmem_we  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_exec_core.sv
// Bench for hack_exec_core: ISA-level reference model, external ALU model and
// memory responders with random ack latency and spurious acks.
module tb_hack_exec_core;

    localparam int AW = 15;
    localparam int MEM_N = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] imem_addr, dmem_addr, pc;
    logic [15:0]   imem_rdata, dmem_rdata, dmem_wdata, alu_x, alu_y, alu_out;
    logic [8:0]    alu_instruction;
    logic          alu_zr, alu_ng;

    always #5 clk = ~clk;

    hack_exec_core #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .alu_x(alu_x), .alu_y(alu_y), .alu_instruction(alu_instruction),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc)
    );

    // Hack ALU: zx nx zy ny f no
    function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? xx + yy : xx & yy;
        if (c[0]) r = ~r;
        return r;
    endfunction

    always_comb begin
        alu_out = alu_f(alu_x, alu_y, alu_instruction[5:0]);
        alu_zr  = (alu_out == 16'h0);
        alu_ng  = alu_out[15];
    end

    int n_chk = 0, n_pass = 0, n_wr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [15:0] prog     [MEM_N];
    logic [15:0] ref_mem  [MEM_N];
    logic [15:0] phys_mem [MEM_N];
    logic [15:0] m_a, m_d;
    int          m_pc;
    int          exp_rd[$], exp_wa[$], exp_wd[$];

    // One instruction at ISA level; records the data accesses it must cause
    task automatic model_step();
        logic [15:0] ins, y, r, old_a;
        int          sr;
        bit          tk;
        ins = prog[m_pc];
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = (m_pc + 1) % MEM_N;
        end else begin
            old_a = m_a;
            if (ins[12]) begin
                y = ref_mem[old_a[14:0]];
                exp_rd.push_back(int'(old_a[14:0]));
            end else begin
                y = old_a;
            end
            r  = alu_f(m_d, y, ins[11:6]);
            sr = int'($signed(r));
            if (ins[3]) begin
                ref_mem[old_a[14:0]] = r;
                exp_wa.push_back(int'(old_a[14:0]));
                exp_wd.push_back(int'(r));
            end
            if (ins[5]) m_a = r;
            if (ins[4]) m_d = r;
            tk   = (ins[2] && sr < 0) || (ins[1] && sr == 0) || (ins[0] && sr > 0);
            m_pc = tk ? int'(old_a[14:0]) : (m_pc + 1) % MEM_N;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < MEM_N; i++) begin
            prog[i]     = ($urandom_range(0, 1) == 1) ? {3'b111, 13'($urandom)}
                                                      : {1'b0, 15'($urandom)};
            ref_mem[i]  = 16'($urandom);
            phys_mem[i] = ref_mem[i];
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_pc", pc, 0);
        chk("rst_d", alu_x, 0);
        chk("rst_addr_wdata", {dmem_addr, dmem_wdata}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_a = 16'h0; m_d = 16'h0; m_pc = 0;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    endtask

    // Runs n instructions, then checks the next fetch and leaves it un-acked.
    // first_wait < 0 picks a random first fetch latency; hold_wr stops at the first write.
    task automatic run_prog(input int n, input int first_wait, input bit hold_wr);
        int iw, dw, iw_set, icyc, cyc, done;
        iw     = (first_wait < 0) ? int'($urandom_range(0, 3)) : first_wait;
        iw_set = iw;
        dw     = $urandom_range(0, 3);
        icyc = 0; cyc = 0; done = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 5000) begin
                chk("timeout", cyc, 0);
                return;
            end
            imem_ack = 1'b0; dmem_ack = 1'b0;
            imem_rdata = 16'($urandom); dmem_rdata = 16'($urandom);
            if (hold_wr && dmem_req && dmem_we) return;
            if (imem_req) begin
                icyc++;
                if (iw == 0) begin
                    chk("fetch_addr", imem_addr, m_pc);
                    chk("pc_port", pc, m_pc);
                    chk("d_reg", alu_x, m_d);
                    chk("req_len", icyc, iw_set + 1);
                    if (done == n) break;
                    imem_rdata = prog[m_pc];
                    model_step();
                    imem_ack = 1'b1;
                    done++;
                    icyc = 0;
                    iw = $urandom_range(0, 3);
                    iw_set = iw;
                end else iw--;
            end else if ($urandom_range(0, 3) == 0) imem_ack = 1'b1;
            if (dmem_req) begin
                if (dw == 0) begin
                    if (dmem_we) begin
                        n_wr++;
                        if (exp_wa.size() == 0) chk("unexpected_write", dmem_addr, 32'hFFFF_FFFF);
                        else begin
                            chk("wr_addr", dmem_addr, exp_wa.pop_front());
                            chk("wr_data", dmem_wdata, exp_wd.pop_front());
                        end
                        phys_mem[dmem_addr] = dmem_wdata;
                    end else begin
                        if (exp_rd.size() == 0) chk("unexpected_read", dmem_addr, 32'hFFFF_FFFF);
                        else chk("rd_addr", dmem_addr, exp_rd.pop_front());
                        dmem_rdata = phys_mem[dmem_addr];
                    end
                    dmem_ack = 1'b1;
                    dw = $urandom_range(0, 3);
                end else dw--;
            end else if ($urandom_range(0, 3) == 0) dmem_ack = 1'b1;
        end
        chk("pending_reads", exp_rd.size(), 0);
        chk("pending_writes", exp_wa.size(), 0);
    endtask

    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0; dmem_rdata = 16'h0;
        @(negedge clk);

        // A-instruction with a 2-cycle fetch wait
        fill_random();
        prog[0] = 16'h0005;
        do_reset();
        n_wr = 0;
        run_prog(1, 2, 1'b0);
        chk("t1_a", alu_y, 16'd5);
        chk("t1_pc", pc, 1);
        chk("t1_no_dmem", n_wr, 0);

        // @7; D=A; @3; D=D+A
        fill_random();
        prog[0] = 16'h0007; prog[1] = 16'hEC10; prog[2] = 16'h0003; prog[3] = 16'hE090;
        do_reset();
        n_wr = 0;
        run_prog(4, -1, 1'b0);
        chk("t2_d", alu_x, 16'd10);
        chk("t2_pc", pc, 4);
        chk("t2_no_write", n_wr, 0);

        // @0x1234; D=A; @100; M=D
        fill_random();
        prog[0] = 16'h1234; prog[1] = 16'hEC10; prog[2] = 16'h0064; prog[3] = 16'hE308;
        do_reset();
        n_wr = 0;
        run_prog(4, -1, 1'b0);
        chk("t3_one_write", n_wr, 1);
        chk("t3_mem", phys_mem[100], 16'h1234);
        chk("t3_pc", pc, 4);

        // @20; AM=M+1;JEQ with mem[20]=0xFFFF
        fill_random();
        prog[0] = 16'h0014; prog[1] = 16'hFDEA;
        ref_mem[20] = 16'hFFFF; phys_mem[20] = 16'hFFFF;
        do_reset();
        run_prog(2, -1, 1'b0);
        chk("t4_mem", phys_mem[20], 16'h0000);
        chk("t4_jump_pc", pc, 20);

        // D=-3 with JGT / JLT, then D=0 with JNE
        for (int k = 0; k < 3; k++) begin
            fill_random();
            prog[0] = 16'h0003;
            prog[1] = (k == 2) ? 16'hEA90 : 16'hECD0;
            prog[2] = 16'h0032;
            prog[3] = (k == 0) ? 16'hE301 : (k == 1) ? 16'hE304 : 16'hE305;
            do_reset();
            run_prog(4, -1, 1'b0);
            chk("t5_pc", pc, (k == 1) ? 50 : 4);
        end

        // Reset while a write is pending, then restart cleanly
        fill_random();
        prog[0] = 16'h0064; prog[1] = 16'hE308;
        do_reset();
        run_prog(2, -1, 1'b1);
        chk("t6_in_write", {dmem_req, dmem_we}, 2'b11);
        prog[0] = 16'h0009; prog[1] = 16'h000A;
        do_reset();
        n_wr = 0;
        run_prog(2, -1, 1'b0);
        chk("t6_no_stale_write", n_wr, 0);

        // Random programs
        for (int r = 0; r < 4; r++) begin
            fill_random();
            do_reset();
            run_prog(80, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
